// File: rtl/instr_dispatch.sv
// Instruction dispatch: single holding register, in-order issue to INT/FPA/FPM/LDST stations gated by RS and ROB credits.
// Optional macro DISPATCH_STATS_EN adds issue/stall statistic counters.
module instr_dispatch #(
  parameter int INT_ENTRIES  = 4,
  parameter int FPA_ENTRIES  = 3,
  parameter int FPM_ENTRIES  = 2,
  parameter int LDST_ENTRIES = 4,
  parameter int ROB_DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [75:0]                  instr_in,
  output logic                         stall_out,
  input  logic                         flush,
  input  logic [3:0]                   rs_free,
  input  logic                         rob_free,
  output logic [3:0]                   issue_valid,
  output logic [75:0]                  issue_instr,
  output logic [$clog2(ROB_DEPTH)-1:0] issue_tag,
  output logic                         illegal_op
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_stall
`endif
);

  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int ROBW  = TAG_W + 1;
  localparam int CRW   = $clog2(INT_ENTRIES + FPA_ENTRIES + FPM_ENTRIES + LDST_ENTRIES + 1);
  localparam logic [ROBW-1:0] ROB_MAX = ROBW'(ROB_DEPTH);
  localparam logic [3:0][CRW-1:0] CRED_MAX = {CRW'(LDST_ENTRIES), CRW'(FPM_ENTRIES),
                                              CRW'(FPA_ENTRIES), CRW'(INT_ENTRIES)};

  logic                 hold_valid_q, hold_valid_d;
  logic [75:0]          hold_instr_q, hold_instr_d;
  logic [3:0][CRW-1:0]  cred_q, cred_d;
  logic [ROBW-1:0]      rob_q, rob_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [3:0]           issue_valid_q, issue_valid_d;
  logic [75:0]          issue_instr_q, issue_instr_d;
  logic [TAG_W-1:0]     issue_tag_q, issue_tag_d;
  logic                 illegal_q, illegal_d;

  logic [3:0] cls;
  logic [3:0] cred_nz;
  logic [3:0] issue_cls;
  logic       illegal;
  logic       can_issue;
  logic       accept;

  always_comb begin
    cls = 4'b0000;
    case (hold_instr_q[75:72])
      4'h0, 4'h1, 4'h2, 4'h3: cls = 4'b0001;
      4'h4, 4'h5:             cls = 4'b0010;
      4'h6:                   cls = 4'b0100;
      4'h7, 4'h8:             cls = 4'b1000;
      default:                cls = 4'b0000;
    endcase
  end

  // stall_out depends only on registered state and flush, never on in_valid
  assign illegal   = hold_valid_q & ~(|cls);
  assign can_issue = hold_valid_q & (|(cls & cred_nz)) & (rob_q != '0);
  assign issue_cls = cls & {4{can_issue}};
  assign stall_out = flush | (hold_valid_q & ~can_issue & ~illegal);
  assign accept    = in_valid & ~stall_out;

  // A simultaneous take and free cancel; frees at the ceiling are dropped
  for (genvar gi = 0; gi < 4; gi++) begin : g_cred
    assign cred_nz[gi] = (cred_q[gi] != '0);
    assign cred_d[gi]  = flush ? CRED_MAX[gi] :
                         (issue_cls[gi] & ~rs_free[gi]) ? cred_q[gi] - CRW'(1) :
                         (~issue_cls[gi] & rs_free[gi] & (cred_q[gi] < CRED_MAX[gi])) ?
                           cred_q[gi] + CRW'(1) : cred_q[gi];
  end

  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_instr_d  = hold_instr_q;
    issue_valid_d = 4'b0000;
    issue_instr_d = issue_instr_q;
    issue_tag_d   = issue_tag_q;
    illegal_d     = 1'b0;
    tag_d         = tag_q;
    rob_d         = rob_q;
    if (flush) begin
      hold_valid_d = 1'b0;
      tag_d        = '0;
      rob_d        = ROB_MAX;
    end else begin
      if (can_issue) begin
        issue_valid_d = cls;
        issue_instr_d = hold_instr_q;
        issue_tag_d   = tag_q;
        tag_d         = tag_q + TAG_W'(1);
      end
      illegal_d = illegal;
      if (can_issue | illegal) hold_valid_d = 1'b0;
      if (accept) begin
        hold_valid_d = 1'b1;
        hold_instr_d = instr_in;
      end
      if (can_issue & ~rob_free)
        rob_d = rob_q - ROBW'(1);
      else if (~can_issue & rob_free & (rob_q < ROB_MAX))
        rob_d = rob_q + ROBW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q  <= 1'b0;
      hold_instr_q  <= '0;
      cred_q        <= CRED_MAX;
      rob_q         <= ROB_MAX;
      tag_q         <= '0;
      issue_valid_q <= 4'b0000;
      issue_instr_q <= '0;
      issue_tag_q   <= '0;
      illegal_q     <= 1'b0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_instr_q  <= hold_instr_d;
      cred_q        <= cred_d;
      rob_q         <= rob_d;
      tag_q         <= tag_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      issue_tag_q   <= issue_tag_d;
      illegal_q     <= illegal_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_instr = issue_instr_q;
  assign issue_tag   = issue_tag_q;
  assign illegal_op  = illegal_q;

`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (flush) begin
      stat_issued_d = '0;
      stat_stall_d  = '0;
    end else begin
      if (|issue_valid_q)            stat_issued_d = stat_issued_q + 32'd1;
      if (hold_valid_q & stall_out)  stat_stall_d  = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed table-driven bench for instr_dispatch: each row gives inputs for one edge plus expected stall/issue results.
module tb_instr_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [75:0] instr_in;
  logic        stall_out;
  logic        flush;
  logic [3:0]  rs_free;
  logic        rob_free;
  logic [3:0]  issue_valid;
  logic [75:0] issue_instr;
  logic [3:0]  issue_tag;
  logic        illegal_op;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  int checks = 0;
  int errors = 0;
  int row_no = 0;

  always #5 clk = ~clk;

  instr_dispatch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .instr_in    (instr_in),
    .stall_out   (stall_out),
    .flush       (flush),
    .rs_free     (rs_free),
    .rob_free    (rob_free),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_tag   (issue_tag),
    .illegal_op  (illegal_op)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  typedef struct {
    logic       iv;
    logic [3:0] op;
    logic [3:0] rsf;
    logic       robf;
    logic       fl;
    logic       st;   // expected stall_out before the edge
    logic [3:0] ev;   // expected issue_valid after the edge
    logic [3:0] et;   // expected tag when ev != 0
    logic [3:0] eop;  // expected issued opcode when ev != 0
    logic       eil;  // expected illegal_op after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic logic [75:0] mk(input logic [3:0] op);
    return {op, {18{op}}};
  endfunction

  function automatic vec_t v(input logic iv, input logic [3:0] op, input logic [3:0] rsf,
                             input logic robf, input logic fl, input logic st,
                             input logic [3:0] ev, input logic [3:0] et,
                             input logic [3:0] eop, input logic eil);
    vec_t r;
    r.iv = iv; r.op = op; r.rsf = rsf; r.robf = robf; r.fl = fl;
    r.st = st; r.ev = ev; r.et = et; r.eop = eop; r.eil = eil;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [75:0] got, input logic [75:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h required %h", nm, row_no, got, exp);
    end
  endtask

  task automatic run_row(input vec_t r);
    in_valid = r.iv;
    instr_in = mk(r.op);
    rs_free  = r.rsf;
    rob_free = r.robf;
    flush    = r.fl;
    #1;
    chk("stall_out", 76'(stall_out), 76'(r.st));
    @(posedge clk);
    #1;
    chk("issue_valid", 76'(issue_valid), 76'(r.ev));
    chk("illegal_op", 76'(illegal_op), 76'(r.eil));
    if (r.ev != 4'b0000) begin
      chk("issue_tag", 76'(issue_tag), 76'(r.et));
      chk("issue_instr", issue_instr, mk(r.eop));
    end
    $display("row %0d: iv=%0b op=%h fl=%0b -> stall=%0b issue=%b tag=%0d ill=%0b",
             row_no, r.iv, r.op, r.fl, stall_out, issue_valid, issue_tag, illegal_op);
    row_no++;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ".issue_valid"}, 76'(issue_valid), 76'd0);
    chk({nm, ".issue_instr"}, issue_instr, 76'd0);
    chk({nm, ".issue_tag"}, 76'(issue_tag), 76'd0);
    chk({nm, ".illegal_op"}, 76'(illegal_op), 76'd0);
    chk({nm, ".stall_out"}, 76'(stall_out), 76'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr_in = '0; flush = 1'b0; rs_free = '0; rob_free = 1'b0;

    // back-to-back stream across all four classes
    tbl.push_back(v(1, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'h4, 0, 0, 0, 0, 4'b0001, 0, 4'h0, 0));
    tbl.push_back(v(1, 4'h6, 0, 0, 0, 0, 4'b0010, 1, 4'h4, 0));
    tbl.push_back(v(1, 4'h7, 0, 0, 0, 0, 4'b0100, 2, 4'h6, 0));
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 4'b1000, 3, 4'h7, 0));
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    // flush refuses the same-cycle instruction
    tbl.push_back(v(1, 4'h0, 0, 0, 1, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    // FPM credit exhaustion, refill, and order blocking of a younger INT op
    tbl.push_back(v(1, 4'h6, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'h6, 0, 0, 0, 0, 4'b0100, 0, 4'h6, 0));
    tbl.push_back(v(1, 4'h6, 0, 0, 0, 0, 4'b0100, 1, 4'h6, 0));
    tbl.push_back(v(1, 4'h6, 0, 0, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'h6, 4'b0100, 0, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'h6, 0, 0, 0, 0, 4'b0100, 2, 4'h6, 0));
    tbl.push_back(v(1, 4'h0, 0, 0, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'h0, 0, 0, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'h0, 4'b0100, 0, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'h0, 0, 0, 0, 0, 4'b0100, 3, 4'h6, 0));
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 4'b0001, 4, 4'h0, 0));
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    // ROB exhaustion: 16 issue, 17th waits for rob_free, then tag wraps to 0
    tbl.push_back(v(0, 4'h0, 0, 0, 1, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'h1, 4'b0001, 0, 0, 0, 4'b0000, 0, 0, 0));
    for (int k = 2; k <= 17; k++)
      tbl.push_back(v(1, 4'h1, 4'b0001, 0, 0, 0, 4'b0001, 4'(k - 2), 4'h1, 0));
    tbl.push_back(v(1, 4'h1, 4'b0001, 0, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 0, 1, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 4'b0001, 0, 4'h1, 0));
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    // illegal opcode is dropped without consuming a tag
    tbl.push_back(v(0, 4'h0, 0, 0, 1, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'hA, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1, 4'h2, 0, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 4'b0001, 0, 4'h2, 0));
    tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) run_row(tbl[i]);

    // frees at the ceiling are ignored: only two FPM issues follow
    run_row(v(0, 4'h0, 0, 0, 1, 1, 4'b0000, 0, 0, 0));
    run_row(v(0, 4'h0, 4'b0100, 1, 0, 0, 4'b0000, 0, 0, 0));
    run_row(v(1, 4'h6, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    run_row(v(1, 4'h6, 0, 0, 0, 0, 4'b0100, 0, 4'h6, 0));
    run_row(v(1, 4'h6, 0, 0, 0, 0, 4'b0100, 1, 4'h6, 0));
    run_row(v(0, 4'h0, 0, 0, 0, 1, 4'b0000, 0, 0, 0));
    // flush while stalled clears hold, restores credits and tag
    run_row(v(1, 4'h0, 0, 0, 1, 1, 4'b0000, 0, 0, 0));
    run_row(v(1, 4'h6, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    run_row(v(1, 4'h0, 0, 0, 0, 0, 4'b0100, 0, 4'h6, 0));

    // asynchronous reset while an issue strobe is high
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_row(v(0, 4'h0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    run_row(v(1, 4'h4, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    run_row(v(0, 4'h0, 0, 0, 0, 0, 4'b0010, 0, 4'h4, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_dispatch.md
Name: instr_dispatch

Overview:
Consumer end of the instruction queue. Accepts one queued instruction per cycle into a single holding register and classifies it by major opcode. Issues it strictly in order to the integer, FP-add, FP-mul or load/store reservation station, gated by per-station credit counters and reorder-buffer (ROB) credits. Back-pressures the queue with stall_out and allocates ROB tags sequentially.

Parameters:
INT_ENTRIES, 4, integer RS depth (credit reset value)
FPA_ENTRIES, 3, FP-add RS depth
FPM_ENTRIES, 2, FP-mul RS depth
LDST_ENTRIES, 4, load/store buffer depth
ROB_DEPTH, 16, ROB entries; power of two; tag width = log2(ROB_DEPTH)

Ports:
clk  in  1  clock; all state on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  queue head valid
instr_in  in  76  {MajorOpcode[75:72], Source1, Source2, OffsetScale, Destination, MinorOpcode, HasAddress, Address[48:1], OffsetSub[0]}
stall_out  out  1  to queue: 1 = do not pop this cycle
flush  in  1  pipeline flush
rs_free  in  4  per-class entry-freed pulses {LDST,FPM,FPA,INT}
rob_free  in  1  ROB retired one entry
issue_valid  out  4  one-hot issue strobe {LDST,FPM,FPA,INT}
issue_instr  out  76  issued instruction
issue_tag  out  log2(ROB_DEPTH)  ROB tag of issued instruction
illegal_op  out  1  one-cycle pulse: illegal opcode dropped

Behaviour:
- Async reset (rst_n=0): hold_valid=0, issue_valid=0, issue_instr=0, issue_tag=0, illegal_op=0, tag pointer=0. Credits = their *_ENTRIES values; ROB credits = ROB_DEPTH. stall_out=0.
- Classification of held MajorOpcode: 0x0-0x3 INT; 0x4-0x5 FPA; 0x6 FPM; 0x7-0x8 LDST; 0x9-0xF illegal.
- can_issue = hold_valid & class credit>0 & rob credit>0 (legal opcode). Illegal opcodes need no credits.
- Accept: stall_out = hold_valid & ~can_issue & ~illegal. Instruction loads into hold when in_valid & ~stall_out. Accept and issue of the previous instruction may occur in the same cycle (full throughput, 1 instr/cycle).
- Latency: accepted at edge N, issue_valid asserted for the cycle after edge N+1 at the earliest. Outputs are registered.
- Issue: issue_valid one-hot for exactly one cycle. issue_instr = held word, issue_tag = tag pointer. Then tag pointer +1 mod ROB_DEPTH, class credit -1, rob credit -1.
- Illegal: held word is discarded; illegal_op pulses one cycle; no tag or credit is consumed; issue_valid stays 0.
- Strict FIFO order: a blocked head blocks all younger instructions, even when their station is free.
- Credits: rs_free[i] adds 1; simultaneous issue and free to the same class leaves the count unchanged. Credits saturate at *_ENTRIES; rob credit saturates at ROB_DEPTH. Frees arriving at max are ignored.
- flush (synchronous, priority over everything except reset): hold_valid=0, issue_valid=0 next cycle, tag pointer=0, all credits restored to reset values. Same-cycle in_valid is not accepted (stall_out=1 while flush=1).
- No combinational path from in_valid to stall_out.

Optional Feature:
DISPATCH_STATS_EN: when defined, adds outputs stat_issued[31:0] (count of issue_valid cycles) and stat_stall[31:0] (count of cycles with hold_valid & stall_out). Both wrap at 2^32, reset to 0 on rst_n and flush. When undefined, these ports and counters do not exist.

Test Plan:
- Reset, then stream opcodes 0x0,0x4,0x6,0x7 back-to-back -> issue_valid 0001,0010,0100,1000 on consecutive cycles; tags 0,1,2,3; stall_out stays 0.
- Five 0x6 with no rs_free -> two issue (tags 0,1). Third held with stall_out=1. rs_free[2] pulse -> third issues next cycle with tag 2.
- Hold blocked 0x6 with FPM credits 0, queue next holds 0x0 -> no INT issue until FPM frees (order preserved).
- 17 INT issues with INT credits refreshed each cycle and no rob_free -> 16 issue with tags 0..15, 17th stalls. One rob_free -> issues with tag 0 (wrap).
- Opcode 0xA -> illegal_op one pulse, no issue_valid, next instr gets unchanged tag.
- Assert flush while stalled, then rst_n low mid-issue -> hold cleared, credits full, tag 0; all outputs 0 immediately on rst_n low.
